// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmitter with one-entry holding register
// A byte can be queued while a frame is on the wire so frames run back-to-back.
module uart_tx_serializer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = 3;

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $fatal(1, "uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 tx_q, tx_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 tx_done_q, tx_done_d;
  logic                 baud_last, load, accept;

  assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign accept    = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        load = hold_valid_q;
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            // Shifter drains LSB first; bit 1 is the next one on the line.
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (idx_q == IDX_W'(STOP_BITS - 1) && baud_q == CNT_W'(CLKS_PER_BIT - 2))
          tx_done_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (hold_valid_q) load = 1'b1;
            else state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      state_d = START;
      shift_d = hold_q;
      baud_d  = '0;
      idx_d   = '0;
      tx_d    = 1'b0;
    end

    hold_valid_d = (hold_valid_q && !load) || accept;
    hold_d       = accept ? in_data : hold_q;
    in_ready_d   = !hold_valid_d;
    busy_d       = (state_d != IDLE) || hold_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
    end
  end

  assign tx       = tx_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - bench for uart_tx_serializer (1 and 2 stop bits)
// A frame-position model predicts every output each cycle; directed literals pin it.
module tb_uart_tx_serializer;

  localparam int CPB = 16;

  logic       clk;
  logic       resetn;
  logic [7:0] in_data0, in_data1;
  logic       in_valid0, in_valid1;
  logic       in_ready0, tx0, busy0, tx_done0;
  logic       in_ready1, tx1, busy1, tx_done1;

  uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .resetn(resetn), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .tx(tx0), .busy(busy0), .tx_done(tx_done0)
  );

  uart_tx_serializer #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .resetn(resetn), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .tx_done(tx_done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int d0[$];
  int d1[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic       s_rstn;
  logic       s_valid [2];
  logic [7:0] s_data  [2];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      s_rstn     <= resetn;
      s_valid[0] <= in_valid0;
      s_valid[1] <= in_valid1;
      s_data[0]  <= in_data0;
      s_data[1]  <= in_data1;
    end
  end

  function automatic int frame_len(input int k);
    return (1 + 8 + k + 1) * CPB;
  endfunction

  function automatic int line_bit(input logic [7:0] b, input int pos);
    int idx;
    idx = pos / CPB;
    if (idx == 0) return 0;
    if (idx <= 8) return int'(b[idx-1]);
    return 1;
  endfunction

  bit         m_active [2];
  int         m_pos    [2];
  logic [7:0] m_byte   [2];
  bit         m_hv     [2];
  logic [7:0] m_hold   [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_pos[k] = 0; m_hv[k] = 0; m_byte[k] = 0; m_hold[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit acc;
        int e_tx, e_done, e_rdy, e_busy;
        int a_tx, a_done, a_rdy, a_busy;
        if (!s_rstn) begin
          m_active[k] = 0;
          m_hv[k]     = 0;
        end else begin
          acc = s_valid[k] && !m_hv[k];
          if (m_active[k]) begin
            if (m_pos[k] == frame_len(k) - 1) m_active[k] = 0;
            else m_pos[k]++;
          end
          if (!m_active[k] && m_hv[k]) begin
            m_active[k] = 1;
            m_pos[k]    = 0;
            m_byte[k]   = m_hold[k];
            m_hv[k]     = 0;
          end
          if (acc) begin
            m_hold[k] = s_data[k];
            m_hv[k]   = 1;
          end
        end
        e_tx   = m_active[k] ? line_bit(m_byte[k], m_pos[k]) : 1;
        e_done = (m_active[k] && m_pos[k] == frame_len(k) - 1) ? 1 : 0;
        e_rdy  = m_hv[k] ? 0 : 1;
        e_busy = (m_active[k] || m_hv[k]) ? 1 : 0;
        a_tx   = int'(k == 0 ? tx0 : tx1);
        a_done = int'(k == 0 ? tx_done0 : tx_done1);
        a_rdy  = int'(k == 0 ? in_ready0 : in_ready1);
        a_busy = int'(k == 0 ? busy0 : busy1);
        check($sformatf("model_tx[%0d]", k), a_tx, e_tx);
        check($sformatf("model_tx_done[%0d]", k), a_done, e_done);
        check($sformatf("model_in_ready[%0d]", k), a_rdy, e_rdy);
        check($sformatf("model_busy[%0d]", k), a_busy, e_busy);
      end
      if (tx_done0) d0.push_back(cyc);
      if (tx_done1) d1.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input int k, input logic [7:0] b, output int e);
    bit rdy;
    int waited;
    waited = 0;
    if (k == 0) begin in_data0 = b; in_valid0 = 1'b1; end
    else        begin in_data1 = b; in_valid1 = 1'b1; end
    do begin
      rdy = (k == 0) ? in_ready0 : in_ready1;
      tick(1);
      waited++;
    end while (!rdy && waited < 400);
    check("send_accepted", int'(rdy), 1);
    e = cyc;
    if (k == 0) in_valid0 = 1'b0;
    else        in_valid1 = 1'b0;
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!tx_done0 && n < 600);
    check("wait_tx_done", int'(tx_done0), 1);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (((k == 0) ? busy0 : busy1) && n < 800) begin
      tick(1);
      n++;
    end
    check("drain_idle", int'((k == 0) ? busy0 : busy1), 0);
  endtask

  initial begin
    int e, e1, e2, ea, eb, ec, ed, lows, rx_byte;
    int bits[10];
    bits = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1};

    resetn = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_data0 = 8'h00; in_data1 = 8'h00;
    tick(3);
    check("rst_tx", int'(tx0), 1);
    check("rst_in_ready", int'(in_ready0), 1);
    check("rst_busy", int'(busy0), 0);
    check("rst_tx_done", int'(tx_done0), 0);
    check("rst_tx_2stop", int'(tx1), 1);
    resetn = 1'b1;
    tick(2);

    // Single byte 0x53.
    send(0, 8'h53, e);
    check("t1_tx_high_at_accept", int'(tx0), 1);
    check("t1_ready_low_at_accept", int'(in_ready0), 0);
    check("t1_busy_at_accept", int'(busy0), 1);
    tick(9);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1_bit%0d", i), int'(tx0), bits[i]);
      if (i < 9) tick(16);
    end
    tick(6);
    check("t1_done_before", int'(tx_done0), 0);
    tick(1);
    check("t1_done_at_160", int'(tx_done0), 1);
    check("t1_done_offset", cyc - e, 160);
    tick(1);
    check("t1_done_after", int'(tx_done0), 0);
    check("t1_busy_after", int'(busy0), 0);
    tick(3);

    // Back-to-back 0x50, 0xFE, 0x45.
    d0.delete();
    send(0, 8'h50, e);
    send(0, 8'hFE, e1);
    send(0, 8'h45, e2);
    drain(0);
    check("b2b_pulses", d0.size(), 3);
    if (d0.size() == 3) begin
      check("b2b_first", d0[0] - e, 160);
      check("b2b_gap1", d0[1] - d0[0], 160);
      check("b2b_gap2", d0[2] - d0[1], 160);
    end
    tick(3);

    // Offers during the last stop cycle, first with hold full, then with hold empty.
    d0.delete();
    send(0, 8'h11, ea);
    send(0, 8'h22, eb);
    wait_done0();
    send(0, 8'h33, ec);
    wait_done0();
    wait_done0();
    send(0, 8'h44, ed);
    check("last_stop_accept_edge", ed - ea, 481);
    drain(0);
    check("ls_pulses", d0.size(), 4);
    if (d0.size() == 4) begin
      check("ls_first", d0[0] - ea, 160);
      check("ls_gap1", d0[1] - d0[0], 160);
      check("ls_gap2", d0[2] - d0[1], 160);
      check("ls_gap3", d0[3] - d0[2], 161);
    end
    tick(3);

    // Reset during data bit 3 of 0xAC with 0x01 queued.
    send(0, 8'hAC, e);
    send(0, 8'h01, e1);
    tick(e + 69 - cyc);
    check("rst_mid_bit3", int'(tx0), 1);
    check("rst_mid_held", int'(in_ready0), 0);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    check("rst_mid_tx", int'(tx0), 1);
    check("rst_mid_ready", int'(in_ready0), 1);
    check("rst_mid_busy", int'(busy0), 0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (!tx0) lows++;
    end
    check("rst_mid_silent", lows, 0);

    // Two stop bits, byte 0x00, decoded by mid-bit sampling.
    d1.delete();
    send(1, 8'h00, e);
    tick(9);
    check("s2_start", int'(tx1), 0);
    rx_byte = 0;
    for (int i = 0; i < 8; i++) begin
      tick(16);
      rx_byte = rx_byte | (int'(tx1) << i);
    end
    check("s2_rx_byte", rx_byte, 0);
    tick(16);
    check("s2_stop1", int'(tx1), 1);
    tick(16);
    check("s2_stop2", int'(tx1), 1);
    drain(1);
    check("s2_pulses", d1.size(), 1);
    if (d1.size() == 1) check("s2_frame_len", d1[0] - e, 176);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
